// File: rtl/lutram_seq_ctrl.sv
// Load/stream sequencer for an externally instantiated LUTRAM image buffer.
// Fills the buffer from a load stream and then replays it to the consumer a programmable number of times.
module lutram_seq_ctrl #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [BIT_DEPTH-1:0]  load_data,
    output logic                  load_ready,
    input  logic                  start,
    input  logic [7:0]            num_passes,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [BIT_DEPTH-1:0]  ram_data_in,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [BIT_DEPTH-1:0]  ram_data_out,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [BIT_DEPTH-1:0]  pix_data,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    output logic                  pix_last,
    output logic                  image_ready,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        LOADED = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    state_t                state_r, state_n_s;
    logic [ADDR_WIDTH-1:0] wr_cnt_r, wr_cnt_n_s;
    logic [ADDR_WIDTH-1:0] rd_cnt_r, rd_cnt_n_s;
    logic [7:0]            pass_cnt_r, pass_cnt_n_s;
    logic [7:0]            passes_r, passes_n_s;
    logic                  pix_valid_r, pix_last_r, image_ready_r, busy_r, done_r;
    logic                  load_ready_s, load_beat_s, start_ok_s;

    // Load handshake: a pending start in LOADED takes priority over a new fill.
    always_comb begin
        load_ready_s = 1'b0;
        case (state_r)
            IDLE, LOAD: load_ready_s = 1'b1;
            LOADED:     load_ready_s = ~start;
            default:    load_ready_s = 1'b0;
        endcase
    end

    assign load_beat_s = load_valid & load_ready_s;
    assign start_ok_s  = (state_r == LOADED) & start & (num_passes != 8'd0);

    // Next-state and counter update; load beats and stream beats never coincide.
    always_comb begin
        state_n_s    = state_r;
        wr_cnt_n_s   = wr_cnt_r;
        rd_cnt_n_s   = rd_cnt_r;
        pass_cnt_n_s = pass_cnt_r;
        passes_n_s   = passes_r;
        case (state_r)
            IDLE, LOAD, LOADED: begin
                if (start_ok_s) begin
                    state_n_s    = STREAM;
                    passes_n_s   = num_passes;
                    rd_cnt_n_s   = {ADDR_WIDTH{1'b0}};
                    pass_cnt_n_s = 8'd0;
                end else if (load_beat_s) begin
                    if (wr_cnt_r == LAST_ADDR) begin
                        wr_cnt_n_s = {ADDR_WIDTH{1'b0}};
                        state_n_s  = LOADED;
                    end else begin
                        wr_cnt_n_s = wr_cnt_r + ADDR_WIDTH'(1);
                        state_n_s  = LOAD;
                    end
                end else begin
                    state_n_s = state_r;
                end
            end
            STREAM: begin
                if (pix_ready) begin
                    if (rd_cnt_r == LAST_ADDR) begin
                        rd_cnt_n_s   = {ADDR_WIDTH{1'b0}};
                        pass_cnt_n_s = pass_cnt_r + 8'd1;
                        if (pass_cnt_r == passes_r - 8'd1) begin
                            state_n_s = DONE;
                        end else begin
                            state_n_s = STREAM;
                        end
                    end else begin
                        rd_cnt_n_s = rd_cnt_r + ADDR_WIDTH'(1);
                    end
                end else begin
                    rd_cnt_n_s = rd_cnt_r;
                end
            end
            DONE:    state_n_s = LOADED;
            default: state_n_s = IDLE;
        endcase
    end

    // State, counters and status flags; flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            wr_cnt_r      <= {ADDR_WIDTH{1'b0}};
            rd_cnt_r      <= {ADDR_WIDTH{1'b0}};
            pass_cnt_r    <= 8'd0;
            passes_r      <= 8'd0;
            pix_valid_r   <= 1'b0;
            pix_last_r    <= 1'b0;
            image_ready_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_n_s;
            wr_cnt_r      <= wr_cnt_n_s;
            rd_cnt_r      <= rd_cnt_n_s;
            pass_cnt_r    <= pass_cnt_n_s;
            passes_r      <= passes_n_s;
            pix_valid_r   <= (state_n_s == STREAM);
            pix_last_r    <= (state_n_s == STREAM) && (rd_cnt_n_s == LAST_ADDR);
            image_ready_r <= (state_n_s == LOADED);
            busy_r        <= (state_n_s == LOAD) || (state_n_s == STREAM);
            done_r        <= (state_n_s == DONE);
        end
    end

    assign load_ready  = load_ready_s;
    assign ram_wr_en   = load_beat_s;
    assign ram_wr_addr = wr_cnt_r;
    assign ram_data_in = load_beat_s ? load_data : {BIT_DEPTH{1'b0}};
    assign ram_rd_addr = rd_cnt_r;
    assign pix_addr    = rd_cnt_r;
    assign pix_data    = pix_valid_r ? ram_data_out : {BIT_DEPTH{1'b0}};
    assign pix_valid   = pix_valid_r;
    assign pix_last    = pix_last_r;
    assign image_ready = image_ready_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_lutram_seq_ctrl.sv
// Self-checking bench for lutram_seq_ctrl: behavioural buffer, expected image array, table and random stimulus.
module tb_lutram_seq_ctrl;

    localparam int BD    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 784;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic [BD-1:0] load_data;
    logic          load_ready;
    logic          start;
    logic [7:0]    num_passes;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [BD-1:0] ram_data_in;
    logic [AW-1:0] ram_rd_addr;
    logic [BD-1:0] ram_data_out;
    logic          pix_valid;
    logic          pix_ready;
    logic [BD-1:0] pix_data;
    logic [AW-1:0] pix_addr;
    logic          pix_last;
    logic          image_ready;
    logic          busy;
    logic          done;

    lutram_seq_ctrl #(.BIT_DEPTH(BD), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .start(start), .num_passes(num_passes),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
        .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_addr(pix_addr), .pix_last(pix_last),
        .image_ready(image_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Behavioural LUTRAM: synchronous write, combinational read.
    logic [BD-1:0] mem [DEPTH];
    always @(posedge clk) if (ram_wr_en) mem[ram_wr_addr] <= ram_data_in;
    assign ram_data_out = mem[ram_rd_addr];

    logic [BD-1:0] img [DEPTH];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       start;
        logic [7:0] np;
        logic       lv;
        logic       exp_lr;
        logic       exp_we;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: ramp data, load_valid held; mode 1: random data, gaps, spurious starts.
    task automatic load_image(input int mode);
        int i = 0;
        int cyc = 0;
        while (i < DEPTH && cyc < DEPTH * 4) begin
            @(negedge clk);
            cyc++;
            if (mode == 0) begin
                load_valid = 1'b1;
                load_data  = BD'(i);
                start      = 1'b0;
            end else begin
                load_valid = ($urandom_range(0, 3) != 0);
                load_data  = BD'($urandom);
                start      = (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                num_passes = 8'($urandom_range(1, 3));
            end
            #1;
            check("load_ready", 32'(load_ready), 32'd1);
            check("load_wr_en", 32'(ram_wr_en), 32'(load_valid));
            check("load_busy", 32'(busy), 32'(i > 0));
            check("load_pix_valid", 32'(pix_valid), 32'd0);
            if (i > 0) check("load_image_ready", 32'(image_ready), 32'd0);
            if (load_valid) begin
                check("load_wr_addr", 32'(ram_wr_addr), 32'(i));
                check("load_wr_data", 32'(ram_data_in), 32'(load_data));
                img[i] = load_data;
                i++;
            end
        end
        check("load_beats", 32'(i), 32'(DEPTH));
        // Cycle after the final beat: start with zero passes blocks loading and is ignored.
        @(negedge clk);
        load_valid = 1'b1; start = 1'b1; num_passes = 8'd0;
        #1;
        check("post_load_ready", 32'(load_ready), 32'd0);
        check("post_load_image_ready", 32'(image_ready), 32'd1);
        check("post_load_wr_en", 32'(ram_wr_en), 32'd0);
        check("post_load_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #1;
        check("np0_image_ready", 32'(image_ready), 32'd1);
        check("np0_pix_valid", 32'(pix_valid), 32'd0);
        check("np0_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] np, input logic lv);
        @(negedge clk);
        start = 1'b1; num_passes = np; load_valid = lv; pix_ready = 1'b0;
        #1;
        check("start_load_ready", 32'(load_ready), 32'd0);
        check("start_wr_en", 32'(ram_wr_en), 32'd0);
        check("start_image_ready", 32'(image_ready), 32'd1);
    endtask

    // mode 0: ready high, 1: toggling, 2: random. abort_at >= 0 pulses rst at that beat.
    task automatic run_stream(input int passes, input int mode, input logic hold_lv, input int abort_at);
        int total = passes * DEPTH;
        int beats = 0;
        int cyc = 0;
        int addr;
        while (beats < total && cyc < total * 4 + 50) begin
            @(negedge clk);
            cyc++;
            start      = 1'($urandom_range(0, 1));
            num_passes = 8'd1;
            load_valid = hold_lv;
            case (mode)
                0:       pix_ready = 1'b1;
                1:       pix_ready = (cyc % 2 == 1);
                default: pix_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (beats == abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_pix_valid", 32'(pix_valid), 32'd0);
                check("abort_image_ready", 32'(image_ready), 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                @(negedge clk);
                rst = 1'b0; start = 1'b0; load_valid = 1'b0;
                return;
            end
            #1;
            addr = beats % DEPTH;
            check("pix_valid", 32'(pix_valid), 32'd1);
            check("pix_addr", 32'(pix_addr), 32'(addr));
            check("ram_rd_addr", 32'(ram_rd_addr), 32'(addr));
            check("pix_data", 32'(pix_data), 32'(img[addr]));
            check("pix_last", 32'(pix_last), 32'(addr == DEPTH - 1));
            check("stream_done", 32'(done), 32'd0);
            check("stream_busy", 32'(busy), 32'd1);
            check("stream_load_ready", 32'(load_ready), 32'd0);
            check("stream_wr_en", 32'(ram_wr_en), 32'd0);
            if (pix_ready) beats++;
        end
        check("stream_beats", 32'(beats), 32'(total));
        @(negedge clk);
        start = 1'b0; load_valid = 1'b0; pix_ready = 1'($urandom_range(0, 1));
        #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_pix_valid", 32'(pix_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_image_ready", 32'(image_ready), 32'd0);
        @(negedge clk);
        #1;
        check("after_done", 32'(done), 32'd0);
        check("after_image_ready", 32'(image_ready), 32'd1);
        check("after_pix_valid", 32'(pix_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{start: 1'b0, np: 8'd0, lv: 1'b0, exp_lr: 1'b1, exp_we: 1'b0};
        vecs[1] = '{start: 1'b0, np: 8'd0, lv: 1'b1, exp_lr: 1'b1, exp_we: 1'b1};
        vecs[2] = '{start: 1'b1, np: 8'd0, lv: 1'b1, exp_lr: 1'b0, exp_we: 1'b0};
        vecs[3] = '{start: 1'b1, np: 8'd2, lv: 1'b1, exp_lr: 1'b0, exp_we: 1'b0};
        vecs[4] = '{start: 1'b1, np: 8'd0, lv: 1'b0, exp_lr: 1'b0, exp_we: 1'b0};
        vecs[5] = '{start: 1'b0, np: 8'd5, lv: 1'b1, exp_lr: 1'b1, exp_we: 1'b1};

        rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0;
        num_passes = 8'd0; pix_ready = 1'b0;
        #2;
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_pix_last", 32'(pix_last), 32'd0);
        check("rst_image_ready", 32'(image_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(ram_wr_en), 32'd0);
        check("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_load_ready", 32'(load_ready), 32'd1);

        load_image(0);

        // Combinational handshake in LOADED, inputs withdrawn before each edge.
        foreach (vecs[k]) begin
            @(negedge clk);
            start = vecs[k].start; num_passes = vecs[k].np; load_valid = vecs[k].lv;
            #1;
            check("vec_load_ready", 32'(load_ready), 32'(vecs[k].exp_lr));
            check("vec_wr_en", 32'(ram_wr_en), 32'(vecs[k].exp_we));
            start = 1'b0; load_valid = 1'b0;
        end
        check("vec_still_loaded", 32'(image_ready), 32'd1);

        do_start(8'd2, 1'b1);
        run_stream(2, 0, 1'b1, -1);
        do_start(8'd2, 1'b0);
        run_stream(2, 1, 1'b0, -1);

        for (int r = 0; r < 2; r++) begin
            int np;
            np = $urandom_range(1, 2);
            load_image(1);
            do_start(8'(np), 1'b0);
            run_stream(np, 2, 1'b0, -1);
        end

        do_start(8'd1, 1'b0);
        run_stream(1, 0, 1'b0, 300);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = 1'b1; num_passes = 8'd1; pix_ready = 1'b1;
            #1;
            check("reset_idle_pix_valid", 32'(pix_valid), 32'd0);
            check("reset_idle_image_ready", 32'(image_ready), 32'd0);
            check("reset_idle_busy", 32'(busy), 32'd0);
            check("reset_idle_load_ready", 32'(load_ready), 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        load_image(0);
        do_start(8'd1, 1'b0);
        run_stream(1, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lutram_seq_ctrl.md
LUTRAM_SEQ_CTRL -- requirements
Module: lutram_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  BIT_DEPTH, 8, pixel width in bits.
  ADDR_WIDTH, 10, address width.
  DEPTH, 784, image size in pixels.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  clk  in  1  single clock, all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  load_valid  in  1  load beat offered.
  load_data  in  BIT_DEPTH  load pixel.
  load_ready  out  1  load beat accepted when high with load_valid.
  start  in  1  begin streaming (sampled in LOADED only).
  num_passes  in  8  passes over image per start, sampled on accepted start.
  ram_wr_en  out  1  buffer write enable.
  ram_wr_addr  out  ADDR_WIDTH  buffer write address.
  ram_data_in  out  BIT_DEPTH  buffer write data.
  ram_rd_addr  out  ADDR_WIDTH  buffer read address.
  ram_data_out  in  BIT_DEPTH  buffer read data, combinational w.r.t. ram_rd_addr.
  pix_valid  out  1  stream beat valid.
  pix_ready  in  1  consumer accepts beat.
  pix_data  out  BIT_DEPTH  stream pixel (= ram_data_out).
  pix_addr  out  ADDR_WIDTH  index of current pixel.
  pix_last  out  1  high on beat with pix_addr = DEPTH-1.
  image_ready  out  1  complete image held (state LOADED).
  busy  out  1  high in LOAD or STREAM.
  done  out  1  one-cycle pulse at end of final pass.

Function
REQ-003 FSM states SHALL be IDLE, LOAD, LOADED, STREAM, DONE.
REQ-004 load_ready SHALL be 1 in IDLE and LOAD, 1 in LOADED only when start=0, 0 in STREAM and DONE.
REQ-005 Load beat (load_valid & load_ready) SHALL drive ram_wr_en=1, ram_wr_addr=wr_cnt, ram_data_in=load_data combinationally same cycle; otherwise ram_wr_en=0.
REQ-006 Load beat SHALL increment wr_cnt; beat from IDLE or LOADED SHALL write address 0 and enter LOAD (LOADED beat restarts fill, image_ready drops next cycle).
REQ-007 Beat at wr_cnt=DEPTH-1 SHALL clear wr_cnt to 0 and enter LOADED next cycle; wr_cnt SHALL never exceed DEPTH-1.
REQ-008 In LOADED, start=1 with num_passes≠0 SHALL latch num_passes, clear rd_cnt and pass_cnt, enter STREAM; start with num_passes=0 SHALL be ignored.
REQ-009 In STREAM, pix_valid=1, ram_rd_addr=pix_addr=rd_cnt, pix_data=ram_data_out; zero latency from address to data.
REQ-010 On pix_valid & pix_ready, rd_cnt SHALL increment; at rd_cnt=DEPTH-1 it SHALL wrap to 0 and pass_cnt increment.
REQ-011 With pix_ready=0, pix_addr, pix_data, pix_last SHALL hold stable.
REQ-012 Accepted beat with pix_last=1 and pass_cnt = latched num_passes-1 SHALL enter DONE; DONE SHALL assert done=1 for exactly one cycle, then enter LOADED (image retained, re-streamable).
REQ-013 start outside LOADED SHALL be ignored; load_valid in STREAM/DONE SHALL not be accepted.
REQ-014 pix_valid, pix_last SHALL be 0 outside STREAM; ram_rd_addr SHALL be rd_cnt at all times.
REQ-015 image_ready SHALL be 1 only in LOADED; busy SHALL be 1 only in LOAD and STREAM.

Reset
REQ-016 rst=1 SHALL asynchronously force IDLE, wr_cnt=rd_cnt=pass_cnt=0, latched passes=0, all outputs 0 except load_ready which SHALL be 1 after release.
REQ-017 Reset mid-LOAD or mid-STREAM SHALL abandon operation; buffer contents are not cleared, and LOADED SHALL be reachable only via a full DEPTH-beat load.

Verification
REQ-018 Bench SHALL cover:
  Load 784 beats, load_data=addr[7:0], load_valid held -> ram_wr_addr 0..783, load_ready=0 and image_ready=1 the cycle after beat 784.
  start, num_passes=2, pix_ready=1 -> 1568 beats, pix_data=pix_addr[7:0], pix_last on beats 784 and 1568, done one cycle after, then image_ready=1.
  pix_ready toggled 1/0 each cycle during STREAM -> pix_addr/pix_data constant across stall cycles, 1568 beats total for 2 passes.
  start=1 and load_valid=1 same cycle in LOADED -> STREAM entered, ram_wr_en=0, no load beat accepted.
  start with num_passes=0 in LOADED -> remains LOADED, pix_valid=0, no done.
  rst pulsed at beat 300 of STREAM -> IDLE immediately, pix_valid=0, image_ready=0; later start ignored until full reload.
